cal_result_tx: RTL and testbench



---
 rtl/cal_result_tx_if.sv | 14 +
 rtl/cal_result_tx.sv | 192 +++++++++++++++++++
 tb/tb_cal_result_tx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cal_result_tx_if.sv
// Calculator-result transmitter bus: result request/data from the calculator side,
// serial line and status back from the transmitter.
interface cal_result_tx_if;
  logic       start;
  logic       sign;
  logic [3:0] msb;
  logic [3:0] lsb;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (output start, sign, msb, lsb, input tx, busy, done);
  modport slave  (input start, sign, msb, lsb, output tx, busy, done);
endinterface

// File: rtl/cal_result_tx.sv
// UART transmitter sending a signed two-digit BCD result as ASCII text plus CR LF.
// Optional even-parity (8E1) framing is enabled by defining CAL_TX_PARITY_EN.
module cal_result_tx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic            clk,
  input  logic            rst_n,
  cal_result_tx_if.slave  bus
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
`ifdef CAL_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_baud_cnt, w_baud_next;
  logic [2:0]    r_bit_idx, w_bit_next;
  logic [2:0]    r_char_idx, w_char_idx_next;
  logic [7:0]    r_char, w_char_next;
  logic          r_sign, w_sign_next;
  logic [3:0]    r_msb, w_msb_next;
  logic [3:0]    r_lsb, w_lsb_next;
  logic          r_tx, w_tx_next;
  logic          r_busy, w_busy_next;
  logic          r_done, w_done_next;

  logic          w_bit_end;
  logic          w_has_tens;
  logic [2:0]    w_lead;
  logic [2:0]    w_rel_idx;
  logic [2:0]    w_last_idx;
  logic [7:0]    w_sel_char;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
  endfunction

  assign w_bit_end  = (r_baud_cnt == BAUD_MAX);
  assign w_has_tens = (r_msb != 4'd0);
  assign w_lead     = {2'b00, r_sign} + {2'b00, w_has_tens};
  assign w_rel_idx  = r_char_idx - w_lead;
  assign w_last_idx = w_lead + 3'd2;

  // Optional prefix characters occupy the first indices; the rest is units, CR, LF.
  always_comb begin
    w_sel_char = 8'h0A;
    if (r_sign && r_char_idx == 3'd0) begin
      w_sel_char = 8'h2D;
    end else if (w_has_tens && r_char_idx == {2'b00, r_sign}) begin
      w_sel_char = digit_char(r_msb);
    end else begin
      case (w_rel_idx)
        3'd0:    w_sel_char = digit_char(r_lsb);
        3'd1:    w_sel_char = 8'h0D;
        default: w_sel_char = 8'h0A;
      endcase
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_baud_next     = '0;
    w_bit_next      = r_bit_idx;
    w_char_idx_next = r_char_idx;
    w_char_next     = r_char;
    w_sign_next     = r_sign;
    w_msb_next      = r_msb;
    w_lsb_next      = r_lsb;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_sign_next     = bus.sign;
          w_msb_next      = bus.msb;
          w_lsb_next      = bus.lsb;
          w_char_idx_next = 3'd0;
          w_state_next    = S_LOAD;
        end
      end
      S_LOAD: begin
        w_char_next  = w_sel_char;
        w_state_next = S_START;
      end
      S_START: begin
        if (w_bit_end) begin
          w_bit_next   = 3'd0;
          w_state_next = S_DATA;
        end else begin
          w_baud_next = r_baud_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_bit_next = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef CAL_TX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end
        end else begin
          w_baud_next = r_baud_cnt + 1'b1;
        end
      end
`ifdef CAL_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_next = S_STOP;
        end else begin
          w_baud_next = r_baud_cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          if (r_char_idx == w_last_idx) begin
            w_state_next = S_DONE;
          end else begin
            w_char_idx_next = r_char_idx + 3'd1;
            w_state_next    = S_LOAD;
          end
        end else begin
          w_baud_next = r_baud_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Outputs are computed for the upcoming state so the flops line up with it.
    w_tx_next = 1'b1;
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = r_char[w_bit_next];
`ifdef CAL_TX_PARITY_EN
      S_PARITY: w_tx_next = ^r_char;
`endif
      default:  w_tx_next = 1'b1;
    endcase
    w_busy_next = (w_state_next != S_IDLE) && (w_state_next != S_DONE);
    w_done_next = (w_state_next == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= 3'd0;
      r_char_idx <= 3'd0;
      r_char     <= 8'h00;
      r_sign     <= 1'b0;
      r_msb      <= 4'd0;
      r_lsb      <= 4'd0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_baud_next;
      r_bit_idx  <= w_bit_next;
      r_char_idx <= w_char_idx_next;
      r_char     <= w_char_next;
      r_sign     <= w_sign_next;
      r_msb      <= w_msb_next;
      r_lsb      <= w_lsb_next;
      r_tx       <= w_tx_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  assign bus.tx   = r_tx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_cal_result_tx.sv
// Bench for cal_result_tx: decodes the serial line and compares against an ASCII string model.
module tb_cal_result_tx;

  localparam int CPB = 4;
`ifdef CAL_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  cal_result_tx_if bus ();

  cal_result_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] digit(input logic [3:0] d);
    return (d > 9) ? 8'h3F : 8'(8'h30 + d);
  endfunction

  // Called on a falling clock edge; returns on the falling edge of the first IDLE cycle.
  task automatic transact(input logic s, input logic [3:0] m, input logic [3:0] l,
                          input bit inject, input int abort_char);
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int n, t0, dc0, w, ts;

    exp_q.delete();
    if (s) exp_q.push_back(8'h2D);
    if (m != 0) exp_q.push_back(digit(m));
    exp_q.push_back(digit(l));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    n = exp_q.size();

    bus.sign = s; bus.msb = m; bus.lsb = l; bus.start = 1'b1;
    t0 = cyc; dc0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b0;
    if (inject) begin
      bus.sign = ~s; bus.msb = 4'($urandom_range(1, 15)); bus.lsb = ~l;
    end
    chk("busy_after_start", bus.busy, 1);

    for (int j = 0; j < n; j++) begin
      w = 0;
      while (bus.tx !== 1'b0 && w < 80) begin @(negedge clk); w++; end
      if (w >= 80) begin
        chk("start_bit_timeout", w, 0);
        return;
      end
      ts = cyc;
      chk("char_start_cycle", ts - t0, 2 + (FRAME_BITS * CPB + 1) * j);
      repeat (CPB / 2) @(negedge clk);
      b = 8'h00;
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        b[k] = bus.tx;
        if (inject && j == 0 && k == 3) begin
          bus.start = 1'b1; bus.sign = 1'b1; bus.msb = 4'd9; bus.lsb = 4'd9;
        end else begin
          bus.start = 1'b0;
        end
        if (j == abort_char && k == 3) begin
          rst_n = 1'b0;
          #1;
          chk("abort_tx", bus.tx, 1);
          chk("abort_busy", bus.busy, 0);
          chk("abort_done", bus.done, 0);
          repeat (3) @(negedge clk);
          rst_n = 1'b1;
          @(negedge clk);
          return;
        end
      end
      chk("data_byte", b, exp_q[j]);
`ifdef CAL_TX_PARITY_EN
      repeat (CPB) @(negedge clk);
      chk("parity_bit", bus.tx, ^b);
`endif
      repeat (CPB) @(negedge clk);
      chk("stop_bit", bus.tx, 1);
    end

    w = 0;
    while (bus.done !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    chk("done_cycle", cyc - t0, 2 + FRAME_BITS * CPB * n + (n - 1));
    chk("busy_in_done", bus.busy, 0);
    // A start in the DONE cycle must be ignored.
    bus.start = 1'b1; bus.sign = 1'b0; bus.msb = 4'd5; bus.lsb = 4'd5;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_done", bus.busy, 0);
    chk("done_pulse_count", done_cnt - dc0, 1);
    chk("done_low_after", bus.done, 0);
  endtask

  initial begin
    int lows;
    logic       rs;
    logic [3:0] rm, rl;

    bus.start = 1'b0; bus.sign = 1'b0; bus.msb = 4'd0; bus.lsb = 4'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", bus.tx, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    rst_n = 1'b1;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) lows++;
    end
    chk("idle_tx_low_cycles", lows, 0);

    transact(1'b0, 4'd1, 4'd2, 1'b0, -1);
    transact(1'b1, 4'd0, 4'd3, 1'b0, -1);
    transact(1'b0, 4'd0, 4'd0, 1'b0, -1);
    transact(1'b0, 4'hC, 4'hA, 1'b0, -1);
    transact(1'b0, 4'd4, 4'd5, 1'b1, -1);
    transact(1'b1, 4'd7, 4'd8, 1'b0, 1);
    transact(1'b1, 4'd6, 4'd2, 1'b0, -1);
    transact(1'b0, 4'd0, 4'd1, 1'b0, -1);
    transact(1'b0, 4'd0, 4'd3, 1'b0, -1);

    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom_range(0, 1));
      rm = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      rl = 4'($urandom_range(0, 15));
      transact(rs, rm, rl, 1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
